// File: rtl/rv_pkg.sv
// Shared RV32I decode constants, issue FSM encoding and instruction field helpers
// used by the ALU issue front end and its register file.
package rv_pkg;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_e;

    function automatic logic [6:0] get_opcode(input logic [31:0] w);
        return w[6:0];
    endfunction

    function automatic logic [4:0] get_rd(input logic [31:0] w);
        return w[11:7];
    endfunction

    function automatic logic [4:0] get_rs1(input logic [31:0] w);
        return w[19:15];
    endfunction

    function automatic logic [4:0] get_rs2(input logic [31:0] w);
        return w[24:20];
    endfunction

    function automatic logic [2:0] get_funct3(input logic [31:0] w);
        return w[14:12];
    endfunction

    function automatic logic [6:0] get_funct7(input logic [31:0] w);
        return w[31:25];
    endfunction

    function automatic logic [31:0] get_iimm(input logic [31:0] w);
        return {{20{w[31]}}, w[31:20]};
    endfunction

endpackage

// File: rtl/rv_alu_issue_if.sv
// Instruction handshake, ALU operand/control and retire signals of rv_alu_issue.
// master is the issue block, slave is the fetch/ALU/retire environment.
interface rv_alu_issue_if;

    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instruction;
    logic [31:0] ALUVAL1;
    logic [31:0] ALUREGVAl2;
    logic [31:0] Iimm;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        ALUReg;
    logic        ALUImmediate;
    logic [31:0] ALUOut;
    logic        retire_valid;
    logic [4:0]  retire_rd;
    logic [31:0] retire_data;
    logic        illegal;

    modport master (
        input  instr_valid, instr, ALUOut,
        output instr_ready, instruction, ALUVAL1, ALUREGVAl2, Iimm, funct3, funct7,
               ALUReg, ALUImmediate, retire_valid, retire_rd, retire_data, illegal
    );

    modport slave (
        output instr_valid, instr, ALUOut,
        input  instr_ready, instruction, ALUVAL1, ALUREGVAl2, Iimm, funct3, funct7,
               ALUReg, ALUImmediate, retire_valid, retire_rd, retire_data, illegal
    );

endinterface

// File: rtl/rv_regfile.sv
// 32x32 integer register file: two operand read ports, one debug read port and a
// single synchronous write port; x0 is never written and always reads zero.
module rv_regfile (
    input  logic        clk,
    input  logic        resetn,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr1,
    output logic [31:0] rdata1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata2,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];

    assign rdata1   = (raddr1   == 5'd0) ? 32'd0 : regs_q[raddr1];
    assign rdata2   = (raddr2   == 5'd0) ? 32'd0 : regs_q[raddr2];
    assign dbg_data = (dbg_addr == 5'd0) ? 32'd0 : regs_q[dbg_addr];

    // Next register contents: apply the write unless it targets x0.
    always_comb begin
        regs_d = regs_q;
        if (we && (waddr != 5'd0)) begin
            regs_d[waddr] = wdata;
        end else begin
            regs_d[0] = 32'd0;
        end
    end

    // Register storage with asynchronous clear of all entries.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

endmodule

// File: rtl/rv_alu_issue.sv
// Single-issue RV32I ALU front end: accepts OP/OP-IMM words, drives an external
// combinational ALU from latched operands, captures its result and writes it back.
module rv_alu_issue
    import rv_pkg::*;
(
    input  logic           clk,
    input  logic           resetn,
    rv_alu_issue_if.master bus,
    input  logic [4:0]     dbg_addr,
    output logic [31:0]    dbg_data
);

    state_e      state_q, state_d;
    logic        instr_ready_q, instr_ready_d;
    logic [31:0] instruction_q, instruction_d;
    logic [31:0] val1_q, val1_d;
    logic [31:0] val2_q, val2_d;
    logic [31:0] iimm_q, iimm_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [6:0]  funct7_q, funct7_d;
    logic        alu_reg_q, alu_reg_d;
    logic        alu_imm_q, alu_imm_d;
    logic        retire_valid_q, retire_valid_d;
    logic [4:0]  retire_rd_q, retire_rd_d;
    logic [31:0] retire_data_q, retire_data_d;
    logic        illegal_q, illegal_d;

    logic        is_op_s, is_opimm_s, is_shift_s, rf_we_s;
    logic [2:0]  instr_f3_s;
    logic [4:0]  rs1_addr_s, rs2_addr_s;
    logic [31:0] rs1_data_s, rs2_data_s;

    assign instr_f3_s = get_funct3(bus.instr);
    assign is_op_s    = (get_opcode(bus.instr) == OPC_OP);
    assign is_opimm_s = (get_opcode(bus.instr) == OPC_OPIMM);
    // OP-IMM shifts carry the arithmetic/logical select in the funct7 field.
    assign is_shift_s = is_opimm_s && (instr_f3_s[1:0] == 2'b01);
    assign rs1_addr_s = get_rs1(bus.instr);
    assign rs2_addr_s = get_rs2(bus.instr);
    assign rf_we_s    = (state_q == ST_WB);

    rv_regfile u_regfile (
        .clk      (clk),
        .resetn   (resetn),
        .we       (rf_we_s),
        .waddr    (retire_rd_q),
        .wdata    (retire_data_q),
        .raddr1   (rs1_addr_s),
        .rdata1   (rs1_data_s),
        .raddr2   (rs2_addr_s),
        .rdata2   (rs2_data_s),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // Next-state and next-output computation for the IDLE/EXEC/WB issue sequence.
    always_comb begin
        state_d        = state_q;
        instr_ready_d  = instr_ready_q;
        instruction_d  = instruction_q;
        val1_d         = val1_q;
        val2_d         = val2_q;
        iimm_d         = iimm_q;
        funct3_d       = funct3_q;
        funct7_d       = funct7_q;
        alu_reg_d      = alu_reg_q;
        alu_imm_d      = alu_imm_q;
        retire_valid_d = 1'b0;
        retire_rd_d    = retire_rd_q;
        retire_data_d  = retire_data_q;
        illegal_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.instr_valid && instr_ready_q) begin
                    if (is_op_s || is_opimm_s) begin
                        state_d       = ST_EXEC;
                        instr_ready_d = 1'b0;
                        instruction_d = bus.instr;
                        val1_d        = rs1_data_s;
                        val2_d        = is_op_s ? rs2_data_s : 32'd0;
                        iimm_d        = get_iimm(bus.instr);
                        funct3_d      = instr_f3_s;
                        funct7_d      = (is_op_s || is_shift_s) ? get_funct7(bus.instr) : 7'd0;
                        alu_reg_d     = is_op_s;
                        alu_imm_d     = is_opimm_s;
                    end else begin
                        illegal_d     = 1'b1;
                        instr_ready_d = 1'b1;
                    end
                end else begin
                    instr_ready_d = 1'b1;
                end
            end
            ST_EXEC: begin
                state_d        = ST_WB;
                retire_valid_d = 1'b1;
                retire_rd_d    = get_rd(instruction_q);
                retire_data_d  = bus.ALUOut;
            end
            ST_WB: begin
                state_d       = ST_IDLE;
                instr_ready_d = 1'b1;
                alu_reg_d     = 1'b0;
                alu_imm_d     = 1'b0;
            end
            default: begin
                state_d       = ST_IDLE;
                instr_ready_d = 1'b0;
                alu_reg_d     = 1'b0;
                alu_imm_d     = 1'b0;
            end
        endcase
    end

    // FSM state and all registered outputs, cleared asynchronously.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= ST_IDLE;
            instr_ready_q  <= 1'b0;
            instruction_q  <= 32'd0;
            val1_q         <= 32'd0;
            val2_q         <= 32'd0;
            iimm_q         <= 32'd0;
            funct3_q       <= 3'd0;
            funct7_q       <= 7'd0;
            alu_reg_q      <= 1'b0;
            alu_imm_q      <= 1'b0;
            retire_valid_q <= 1'b0;
            retire_rd_q    <= 5'd0;
            retire_data_q  <= 32'd0;
            illegal_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            instr_ready_q  <= instr_ready_d;
            instruction_q  <= instruction_d;
            val1_q         <= val1_d;
            val2_q         <= val2_d;
            iimm_q         <= iimm_d;
            funct3_q       <= funct3_d;
            funct7_q       <= funct7_d;
            alu_reg_q      <= alu_reg_d;
            alu_imm_q      <= alu_imm_d;
            retire_valid_q <= retire_valid_d;
            retire_rd_q    <= retire_rd_d;
            retire_data_q  <= retire_data_d;
            illegal_q      <= illegal_d;
        end
    end

    assign bus.instr_ready  = instr_ready_q;
    assign bus.instruction  = instruction_q;
    assign bus.ALUVAL1      = val1_q;
    assign bus.ALUREGVAl2   = val2_q;
    assign bus.Iimm         = iimm_q;
    assign bus.funct3       = funct3_q;
    assign bus.funct7       = funct7_q;
    assign bus.ALUReg       = alu_reg_q;
    assign bus.ALUImmediate = alu_imm_q;
    assign bus.retire_valid = retire_valid_q;
    assign bus.retire_rd    = retire_rd_q;
    assign bus.retire_data  = retire_data_q;
    assign bus.illegal      = illegal_q;

endmodule

// File: tb/tb_rv_alu_issue.sv
// Scoreboard bench for rv_alu_issue with a behavioural RV32I ALU closing the loop.
module tb_rv_alu_issue;

    logic        clk;
    logic        resetn;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic [31:0] alu_b;

    rv_alu_issue_if bus ();

    rv_alu_issue dut (
        .clk      (clk),
        .resetn   (resetn),
        .bus      (bus),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        int          cyc;
    } ret_t;

    ret_t exp_q [$];
    ret_t obs_q [$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   acc_cnt  = 0;
    int   last_acc = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference ALU beside the issue block.
    always_comb begin
        alu_b = bus.ALUReg ? bus.ALUREGVAl2 : bus.Iimm;
        case (bus.funct3)
            3'b000: bus.ALUOut = (bus.ALUReg && bus.funct7[5]) ? bus.ALUVAL1 - alu_b : bus.ALUVAL1 + alu_b;
            3'b001: bus.ALUOut = bus.ALUVAL1 << alu_b[4:0];
            3'b010: bus.ALUOut = {31'd0, $signed(bus.ALUVAL1) < $signed(alu_b)};
            3'b011: bus.ALUOut = {31'd0, bus.ALUVAL1 < alu_b};
            3'b100: bus.ALUOut = bus.ALUVAL1 ^ alu_b;
            3'b101: bus.ALUOut = bus.funct7[5] ? $unsigned($signed(bus.ALUVAL1) >>> alu_b[4:0])
                                               : bus.ALUVAL1 >> alu_b[4:0];
            3'b110: bus.ALUOut = bus.ALUVAL1 | alu_b;
            default: bus.ALUOut = bus.ALUVAL1 & alu_b;
        endcase
    end

    // Cycle counter and handshake observer.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.instr_valid === 1'b1 && bus.instr_ready === 1'b1) begin
            acc_cnt  <= acc_cnt + 1;
            last_acc <= cyc;
        end
    end

    // Retire monitor feeding the observed queue.
    always @(negedge clk) begin
        if (bus.retire_valid === 1'b1) begin
            obs_q.push_back('{bus.retire_rd, bus.retire_data, cyc});
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (bus.instr_ready !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Offers one word at the next ready IDLE cycle; returns at the negedge after the accept edge.
    task automatic send(input logic [31:0] w);
        @(negedge clk);
        wait_ready();
        bus.instr       = w;
        bus.instr_valid = 1'b1;
        @(negedge clk);
        bus.instr_valid = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.instr_ready, bus.retire_valid, bus.illegal, bus.ALUReg, bus.ALUImmediate} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b, expected 00000",
                     {bus.instr_ready, bus.retire_valid, bus.illegal, bus.ALUReg, bus.ALUImmediate});
        end
        n_checks++;
        if ({bus.ALUVAL1, bus.ALUREGVAl2, bus.Iimm, bus.instruction, bus.retire_data} !== 160'd0) begin
            n_fail++;
            $display("FAIL reset_data: got val1=%h val2=%h imm=%h ins=%h rdata=%h, expected all 0",
                     bus.ALUVAL1, bus.ALUREGVAl2, bus.Iimm, bus.instruction, bus.retire_data);
        end
        n_checks++;
        if ({bus.funct3, bus.funct7, bus.retire_rd} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_fields: got f3=%0d f7=%0d rd=%0d, expected 0",
                     bus.funct3, bus.funct7, bus.retire_rd);
        end
        resetn = 1'b1;
        #1;
        n_checks++;
        if (bus.instr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_before_clock: got %b, expected 0", bus.instr_ready);
        end
        @(negedge clk);
        n_checks++;
        if (bus.instr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_clock: got %b, expected 1", bus.instr_ready);
        end
    endtask

    task automatic test_addi();
        ret_t o, e;
        exp_q.push_back('{5'd1, 32'd5, 0});
        exp_q.push_back('{5'd2, 32'd3, 0});
        send(32'h00500093);
        send(32'h00300113);
        repeat (5) @(negedge clk);
        #1;
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL addi_count: got %0d retires, expected %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_checks++;
            if (o.rd !== e.rd || o.data !== e.data) begin
                n_fail++;
                $display("FAIL addi_retire: got rd=%0d data=%h, expected rd=%0d data=%h", o.rd, o.data, e.rd, e.data);
            end
        end
        exp_q.delete();
        obs_q.delete();
        dbg_addr = 5'd1;
        #1;
        n_checks++;
        if (dbg_data !== 32'd5) begin
            n_fail++;
            $display("FAIL dbg_x1: got %h, expected 00000005", dbg_data);
        end
        dbg_addr = 5'd2;
        #1;
        n_checks++;
        if (dbg_data !== 32'd3) begin
            n_fail++;
            $display("FAIL dbg_x2: got %h, expected 00000003", dbg_data);
        end
    endtask

    task automatic test_add();
        ret_t o;
        @(negedge clk);
        wait_ready();
        bus.instr       = 32'h002081B3;
        bus.instr_valid = 1'b1;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        n_checks++;
        if (bus.ALUVAL1 !== 32'd5 || bus.ALUREGVAl2 !== 32'd3) begin
            n_fail++;
            $display("FAIL add_operands: got %h/%h, expected 00000005/00000003", bus.ALUVAL1, bus.ALUREGVAl2);
        end
        n_checks++;
        if ({bus.ALUReg, bus.ALUImmediate, bus.funct3, bus.funct7} !== {1'b1, 1'b0, 3'd0, 7'd0}) begin
            n_fail++;
            $display("FAIL add_ctrl: got reg=%b imm=%b f3=%0d f7=%0d, expected reg=1 imm=0 f3=0 f7=0",
                     bus.ALUReg, bus.ALUImmediate, bus.funct3, bus.funct7);
        end
        n_checks++;
        if (bus.instruction !== 32'h002081B3) begin
            n_fail++;
            $display("FAIL add_instruction: got %h, expected 002081b3", bus.instruction);
        end
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (obs_q.size() != 1) begin
            n_fail++;
            $display("FAIL add_count: got %0d retires, expected 1", obs_q.size());
        end else begin
            o = obs_q.pop_front();
            n_checks++;
            if (o.rd !== 5'd3 || o.data !== 32'd8) begin
                n_fail++;
                $display("FAIL add_retire: got rd=%0d data=%h, expected rd=3 data=00000008", o.rd, o.data);
            end
            n_checks++;
            if (o.cyc - last_acc != 2) begin
                n_fail++;
                $display("FAIL add_latency: got %0d cycles, expected 2", o.cyc - last_acc);
            end
        end
        obs_q.delete();
        n_checks++;
        if (bus.ALUReg !== 1'b0 || bus.ALUVAL1 !== 32'd5) begin
            n_fail++;
            $display("FAIL idle_hold: got reg=%b val1=%h, expected reg=0 val1=00000005", bus.ALUReg, bus.ALUVAL1);
        end
    endtask

    task automatic test_funct7();
        ret_t o, e;
        exp_q.push_back('{5'd4, 32'd2, 0});
        exp_q.push_back('{5'd8, 32'd1, 0});
        send(32'h40208233);
        n_checks++;
        if (bus.funct7 !== 7'b0100000 || bus.ALUReg !== 1'b1) begin
            n_fail++;
            $display("FAIL sub_funct7: got f7=%b reg=%b, expected f7=0100000 reg=1", bus.funct7, bus.ALUReg);
        end
        send(32'h40125413);
        n_checks++;
        if (bus.funct7 !== 7'b0100000 || bus.ALUImmediate !== 1'b1 || bus.funct3 !== 3'b101) begin
            n_fail++;
            $display("FAIL srai_ctrl: got f7=%b imm=%b f3=%b, expected f7=0100000 imm=1 f3=101",
                     bus.funct7, bus.ALUImmediate, bus.funct3);
        end
        n_checks++;
        if (bus.Iimm !== 32'h00000401 || bus.ALUREGVAl2 !== 32'd0) begin
            n_fail++;
            $display("FAIL srai_ops: got Iimm=%h val2=%h, expected 00000401/00000000", bus.Iimm, bus.ALUREGVAl2);
        end
        repeat (5) @(negedge clk);
        #1;
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL f7_count: got %0d retires, expected %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_checks++;
            if (o.rd !== e.rd || o.data !== e.data) begin
                n_fail++;
                $display("FAIL f7_retire: got rd=%0d data=%h, expected rd=%0d data=%h", o.rd, o.data, e.rd, e.data);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_x0();
        ret_t o;
        send(32'h00700013);
        n_checks++;
        if ({bus.ALUImmediate, bus.ALUReg, bus.funct7} !== {1'b1, 1'b0, 7'd0}
            || bus.Iimm !== 32'd7 || bus.ALUREGVAl2 !== 32'd0) begin
            n_fail++;
            $display("FAIL x0_ctrl: got imm=%b reg=%b f7=%0d Iimm=%h val2=%h, expected 1 0 0 00000007 00000000",
                     bus.ALUImmediate, bus.ALUReg, bus.funct7, bus.Iimm, bus.ALUREGVAl2);
        end
        repeat (4) @(negedge clk);
        #1;
        n_checks++;
        if (obs_q.size() != 1) begin
            n_fail++;
            $display("FAIL x0_count: got %0d retires, expected 1", obs_q.size());
        end else begin
            o = obs_q.pop_front();
            n_checks++;
            if (o.rd !== 5'd0 || o.data !== 32'd7) begin
                n_fail++;
                $display("FAIL x0_retire: got rd=%0d data=%h, expected rd=0 data=00000007", o.rd, o.data);
            end
        end
        obs_q.delete();
        dbg_addr = 5'd0;
        #1;
        n_checks++;
        if (dbg_data !== 32'd0) begin
            n_fail++;
            $display("FAIL dbg_x0: got %h, expected 00000000", dbg_data);
        end
    endtask

    task automatic test_illegal();
        @(negedge clk);
        wait_ready();
        bus.instr       = 32'h00000000;
        bus.instr_valid = 1'b1;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        n_checks++;
        if ({bus.illegal, bus.instr_ready, bus.retire_valid, bus.ALUReg} !== 4'b1100) begin
            n_fail++;
            $display("FAIL illegal_pulse: got ill=%b rdy=%b ret=%b reg=%b, expected 1 1 0 0",
                     bus.illegal, bus.instr_ready, bus.retire_valid, bus.ALUReg);
        end
        n_checks++;
        if (bus.instruction !== 32'h00700013) begin
            n_fail++;
            $display("FAIL illegal_nolatch: got %h, expected 00700013", bus.instruction);
        end
        @(negedge clk);
        n_checks++;
        if (bus.illegal !== 1'b0 || bus.instr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_width: got ill=%b rdy=%b, expected 0 1", bus.illegal, bus.instr_ready);
        end
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL illegal_retire: got %0d retires, expected 0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [3];
        int          idx = 0;
        int          a0;
        int          seen;
        ret_t        o, e;
        words[0] = 32'h00900293;
        words[1] = 32'h00528333;
        words[2] = 32'h405303B3;
        exp_q.push_back('{5'd5, 32'd9, 0});
        exp_q.push_back('{5'd6, 32'd18, 0});
        exp_q.push_back('{5'd7, 32'd9, 0});
        @(negedge clk);
        wait_ready();
        a0              = acc_cnt;
        seen            = acc_cnt;
        bus.instr       = words[0];
        bus.instr_valid = 1'b1;
        repeat (9) begin
            @(negedge clk);
            if (acc_cnt != seen) begin
                seen = acc_cnt;
                idx++;
                if (idx < 3) bus.instr = words[idx];
                else bus.instr_valid = 1'b0;
            end
        end
        bus.instr_valid = 1'b0;
        n_checks++;
        if (acc_cnt - a0 != 3) begin
            n_fail++;
            $display("FAIL b2b_accepts: got %0d accepts in 9 cycles, expected 3", acc_cnt - a0);
        end
        repeat (4) @(negedge clk);
        #1;
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d retires, expected %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_checks++;
            if (o.rd !== e.rd || o.data !== e.data) begin
                n_fail++;
                $display("FAIL b2b_retire: got rd=%0d data=%h, expected rd=%0d data=%h", o.rd, o.data, e.rd, e.data);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset_mid_exec();
        send(32'h05500493);
        resetn = 1'b0;
        #1;
        n_checks++;
        if ({bus.instr_ready, bus.retire_valid, bus.illegal, bus.ALUReg, bus.ALUImmediate,
             bus.funct3, bus.funct7, bus.retire_rd} !== 20'd0) begin
            n_fail++;
            $display("FAIL midreset_ctrl: got rdy=%b ret=%b ill=%b reg=%b imm=%b, expected all 0",
                     bus.instr_ready, bus.retire_valid, bus.illegal, bus.ALUReg, bus.ALUImmediate);
        end
        n_checks++;
        if ({bus.ALUVAL1, bus.ALUREGVAl2, bus.Iimm, bus.instruction, bus.retire_data} !== 160'd0) begin
            n_fail++;
            $display("FAIL midreset_data: got val1=%h val2=%h imm=%h ins=%h rdata=%h, expected all 0",
                     bus.ALUVAL1, bus.ALUREGVAl2, bus.Iimm, bus.instruction, bus.retire_data);
        end
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            #1;
            n_checks++;
            if (dbg_data !== 32'd0) begin
                n_fail++;
                $display("FAIL midreset_reg: x%0d got %h, expected 00000000", i, dbg_data);
            end
        end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        n_checks++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL midreset_retire: got %0d retires, expected 0", obs_q.size());
        end
        dbg_addr = 5'd9;
        #1;
        n_checks++;
        if (dbg_data !== 32'd0 || bus.instr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_after: got x9=%h rdy=%b, expected 00000000 1", dbg_data, bus.instr_ready);
        end
        obs_q.delete();
    endtask

    initial begin
        resetn          = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr       = 32'd0;
        dbg_addr        = 5'd0;
        #1;
        test_reset();
        test_addi();
        test_add();
        test_funct7();
        test_x0();
        test_illegal();
        test_back_to_back();
        test_reset_mid_exec();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
